// File: rtl/lb_window_if.sv
// Pixel-in / window-out stream bundle for the lb_window line buffer.
// Handshake: a beat transfers on a rising edge where valid && ready; valid never waits on ready, payload holds while valid && !ready.
interface lb_window_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ROWS       = 3,
   parameter int WIN_COLS   = 3
) ();
   logic                               s_valid;
   logic                               s_ready;
   logic [DATA_WIDTH-1:0]              s_data;
   logic                               s_sof;
   logic                               m_valid;
   logic                               m_ready;
   logic [ROWS*WIN_COLS*DATA_WIDTH-1:0] m_data;
   logic                               m_sof;
   logic                               m_eol;

   modport slave (
      input  s_valid, s_data, s_sof, m_ready,
      output s_ready, m_valid, m_data, m_sof, m_eol
   );

   modport master (
      output s_valid, s_data, s_sof, m_ready,
      input  s_ready, m_valid, m_data, m_sof, m_eol
   );
endinterface

// File: rtl/lb_window.sv
// Streaming line buffer: circular row memory plus column shift register
// producing a ROWS x WIN_COLS window per accepted pixel, with a registered output stage.
module lb_window #(
   parameter int DATA_WIDTH = 32,
   parameter int ROWS       = 3,
   parameter int ROW_WIDTH  = 5,
   parameter int WIN_COLS   = 3
) (
   input  logic       clk,
   input  logic       rst,
   lb_window_if.slave bus,
   output logic       primed
);
   localparam int LINES = ROWS - 1;
   localparam int CW    = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
   localparam int OW    = (LINES > 1) ? $clog2(LINES) : 1;
   localparam int RW    = $clog2(ROWS);
   localparam int WW    = ROWS * WIN_COLS * DATA_WIDTH;
   localparam logic [CW-1:0] LAST_COL   = CW'(ROW_WIDTH - 1);
   localparam logic [OW-1:0] LAST_ORDER = OW'(LINES - 1);
   localparam logic [RW-1:0] FULL_ROWS  = RW'(ROWS - 1);

   if (ROWS < 2 || WIN_COLS < 1 || WIN_COLS > ROW_WIDTH) begin : g_bad_params
      $error("lb_window: illegal ROWS / WIN_COLS / ROW_WIDTH combination");
   end

   logic [DATA_WIDTH-1:0] mem     [LINES][ROW_WIDTH];
   logic [DATA_WIDTH-1:0] win_q   [ROWS][WIN_COLS];
   logic [DATA_WIDTH-1:0] win_d   [ROWS][WIN_COLS];
   logic [DATA_WIDTH-1:0] col_vec [ROWS];
   logic [WW-1:0]         win_flat;
   logic [CW-1:0]         wr_col, col_eff, col_nxt;
   logic [OW-1:0]         wr_order, order_eff, order_nxt;
   logic [RW-1:0]         rows_done, rows_eff, rows_nxt;
   logic                  first_q, first_eff;
   logic                  accept, emit, eol, col_ok;
   logic                  m_valid_q, m_sof_q, m_eol_q;
   logic [WW-1:0]         m_data_q;

   assign bus.s_ready = !rst && (!m_valid_q || bus.m_ready);
   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = m_data_q;
   assign bus.m_sof   = m_sof_q;
   assign bus.m_eol   = m_eol_q;
   assign accept      = bus.s_valid && bus.s_ready;
   assign primed      = (rows_done == FULL_ROWS);

   // A single-column window is complete on every pixel of a full line.
   if (WIN_COLS > 1) begin : g_col_ok
      localparam logic [CW-1:0] FIRST_EMIT_COL = CW'(WIN_COLS - 1);
      assign col_ok = (col_eff >= FIRST_EMIT_COL);
   end else begin : g_col_ok_one
      assign col_ok = 1'b1;
   end

   // An accepted sof pixel behaves as line 0, column 0, whatever the counters held.
   always_comb begin : p_counters
      col_eff   = bus.s_sof ? '0 : wr_col;
      order_eff = bus.s_sof ? '0 : wr_order;
      rows_eff  = bus.s_sof ? '0 : rows_done;
      first_eff = bus.s_sof || first_q;
      eol       = (col_eff == LAST_COL);
      emit      = accept && (rows_eff == FULL_ROWS) && col_ok;
      col_nxt   = eol ? '0 : col_eff + 1'b1;
      order_nxt = order_eff;
      rows_nxt  = rows_eff;
      if (eol) begin
         order_nxt = (order_eff == LAST_ORDER) ? '0 : order_eff + 1'b1;
         if (rows_eff != FULL_ROWS) rows_nxt = rows_eff + 1'b1;
      end
   end

   always_comb begin : p_window
      logic [OW:0] sum;
      sum      = '0;
      win_flat = '0;
      for (int k = 0; k < LINES; k++) begin
         sum = {1'b0, order_eff} + (OW+1)'(k);
         if (sum >= (OW+1)'(LINES)) sum = sum - (OW+1)'(LINES);
         col_vec[k] = mem[sum[OW-1:0]][col_eff];
      end
      col_vec[ROWS-1] = bus.s_data;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < WIN_COLS - 1; c++) win_d[r][c] = win_q[r][c+1];
         win_d[r][WIN_COLS-1] = col_vec[r];
      end
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < WIN_COLS; c++)
            win_flat[(r*WIN_COLS+c)*DATA_WIDTH +: DATA_WIDTH] = win_d[r][c];
   end

   // The read in p_window sees the pre-write value of the same slot.
   always_ff @(posedge clk) begin
      if (accept) mem[order_eff][col_eff] <= bus.s_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_col    <= '0;
         wr_order  <= '0;
         rows_done <= '0;
         first_q   <= 1'b1;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_sof_q   <= 1'b0;
         m_eol_q   <= 1'b0;
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < WIN_COLS; c++) win_q[r][c] <= '0;
      end else begin
         if (accept) begin
            wr_col    <= col_nxt;
            wr_order  <= order_nxt;
            rows_done <= rows_nxt;
            win_q     <= win_d;
            first_q   <= emit ? 1'b0 : first_eff;
         end
         if (emit) begin
            m_valid_q <= 1'b1;
            m_data_q  <= win_flat;
            m_sof_q   <= first_eff;
            m_eol_q   <= eol;
         end else if (m_valid_q && bus.m_ready) begin
            m_valid_q <= 1'b0;
         end
      end
   end
endmodule
